// File: rtl/cpu_halt_ctrl_pkg.sv
// Shared definitions for the core halt/run handshake controller.
package cpu_halt_ctrl_pkg;

   localparam int unsigned CPU_HALT_ACK_TIMEOUT_DEFAULT = 32'd255;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_HALT_REQ = 2'b01,
      ST_HALTED   = 2'b10,
      ST_RUN_REQ  = 2'b11
   } halt_state_e;

endpackage

// File: rtl/cpu_halt_ctrl.sv
// Core halt/run handshake controller: firmware requests a halt, wake events request resume,
// and a saturating wait counter flags a missing core acknowledge.
module cpu_halt_ctrl
   import cpu_halt_ctrl_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = CPU_HALT_ACK_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic cptra_rst_b,
   input  logic fw_halt_req,
   input  logic wake_event,
   input  logic cptra_in_debug_scan_mode,
   input  logic cpu_halt_ack,
   input  logic cpu_run_ack,
   output logic cpu_halt_req,
   output logic cpu_run_req,
   output logic cpu_halt_status,
   output logic halt_timeout_err
);

   localparam int unsigned CNT_W = (ACK_TIMEOUT < 32'd2) ? 32'd1 : 32'($clog2(ACK_TIMEOUT + 32'd1));
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

   halt_state_e      state_r;
   halt_state_e      state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             timeout_s;
   logic             cnt_restart_s;
   logic             err_nxt_s;
   logic             cpu_halt_req_r;
   logic             cpu_run_req_r;
   logic             cpu_halt_status_r;
   logic             halt_timeout_err_r;

   assign timeout_s        = (cnt_r == CNT_MAX);
   assign cpu_halt_req     = cpu_halt_req_r;
   assign cpu_run_req      = cpu_run_req_r;
   assign cpu_halt_status  = cpu_halt_status_r;
   assign halt_timeout_err = halt_timeout_err_r;

   // Next-state decode; an ack always beats a same-cycle timeout or wake.
   always_comb begin
      state_nxt_s   = state_r;
      err_nxt_s     = 1'b0;
      cnt_restart_s = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (fw_halt_req && !wake_event && !cptra_in_debug_scan_mode) begin
               state_nxt_s = ST_HALT_REQ;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_HALT_REQ: begin
            if (cpu_halt_ack) begin
               state_nxt_s = ST_HALTED;
            end else if (timeout_s) begin
               state_nxt_s = ST_RUN;
               err_nxt_s   = 1'b1;
            end else if (wake_event) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_HALT_REQ;
            end
         end
         ST_HALTED: begin
            if (wake_event) begin
               state_nxt_s = ST_RUN_REQ;
            end else begin
               state_nxt_s = ST_HALTED;
            end
         end
         ST_RUN_REQ: begin
            if (cpu_run_ack) begin
               state_nxt_s = ST_RUN;
            end else if (timeout_s) begin
               // Keep asking the core to resume, but report the stall and re-arm the wait.
               state_nxt_s   = ST_RUN_REQ;
               err_nxt_s     = 1'b1;
               cnt_restart_s = 1'b1;
            end else begin
               state_nxt_s = ST_RUN_REQ;
            end
         end
         default: begin
            state_nxt_s = ST_RUN;
         end
      endcase
   end

   // Wait counter: cleared on any state entry or restart, saturates at the timeout value.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if ((state_nxt_s != state_r) || cnt_restart_s) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (((state_r == ST_HALT_REQ) || (state_r == ST_RUN_REQ)) && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // State register and wait counter.
   always_ff @(posedge clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         state_r <= ST_RUN;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Outputs decode the next state so they change on the edge that enters it.
   always_ff @(posedge clk or negedge cptra_rst_b) begin
      if (!cptra_rst_b) begin
         cpu_halt_req_r     <= 1'b0;
         cpu_run_req_r      <= 1'b0;
         cpu_halt_status_r  <= 1'b0;
         halt_timeout_err_r <= 1'b0;
      end else begin
         cpu_halt_req_r     <= (state_nxt_s == ST_HALT_REQ);
         cpu_run_req_r      <= (state_nxt_s == ST_RUN_REQ);
         cpu_halt_status_r  <= (state_nxt_s == ST_HALTED);
         halt_timeout_err_r <= err_nxt_s;
      end
   end

endmodule

// File: tb/tb_cpu_halt_ctrl.sv
// Scoreboard bench for cpu_halt_ctrl: directed handshake scenarios plus randomized traffic.
module tb_cpu_halt_ctrl;

   localparam int T = 8;

   logic clk = 1'b0;
   logic cptra_rst_b = 1'b0;
   logic fw_halt_req = 1'b0;
   logic wake_event = 1'b0;
   logic cptra_in_debug_scan_mode = 1'b0;
   logic cpu_halt_ack = 1'b0;
   logic cpu_run_ack = 1'b0;
   logic cpu_halt_req;
   logic cpu_run_req;
   logic cpu_halt_status;
   logic halt_timeout_err;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q[$];

   // Reference model: is the core halted, which handshake is outstanding, how long it has waited.
   bit m_halted;
   int m_pending;   // 0 none, 1 waiting for halt ack, 2 waiting for run ack
   int m_waited;
   bit m_err;

   cpu_halt_ctrl #(.ACK_TIMEOUT(T)) dut (
      .clk                      (clk),
      .cptra_rst_b              (cptra_rst_b),
      .fw_halt_req              (fw_halt_req),
      .wake_event               (wake_event),
      .cptra_in_debug_scan_mode (cptra_in_debug_scan_mode),
      .cpu_halt_ack             (cpu_halt_ack),
      .cpu_run_ack              (cpu_run_ack),
      .cpu_halt_req             (cpu_halt_req),
      .cpu_run_req              (cpu_run_req),
      .cpu_halt_status          (cpu_halt_status),
      .halt_timeout_err         (halt_timeout_err)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_halted  = 1'b0;
      m_pending = 0;
      m_waited  = 0;
      m_err     = 1'b0;
   endfunction

   function automatic logic [3:0] model_step(input bit f, input bit w, input bit s,
                                             input bit ha, input bit ra);
      m_err = 1'b0;
      if (m_pending == 1) begin
         if (ha) begin
            m_pending = 0; m_halted = 1'b1;
         end else if (m_waited == T) begin
            m_pending = 0; m_err = 1'b1;
         end else if (w) begin
            m_pending = 0;
         end else begin
            m_waited++;
         end
      end else if (m_pending == 2) begin
         if (ra) begin
            m_pending = 0; m_halted = 1'b0;
         end else if (m_waited == T) begin
            m_err = 1'b1; m_waited = 0;
         end else begin
            m_waited++;
         end
      end else if (m_halted) begin
         if (w) begin
            m_pending = 2; m_waited = 0;
         end
      end else if (f && !w && !s) begin
         m_pending = 1; m_waited = 0;
      end
      return {m_pending == 1, m_pending == 2, m_halted && (m_pending == 0), m_err};
   endfunction

   task automatic step(input bit f, input bit w, input bit s, input bit ha, input bit ra);
      @(negedge clk);
      cptra_rst_b              = 1'b1;
      fw_halt_req              = f;
      wake_event               = w;
      cptra_in_debug_scan_mode = s;
      cpu_halt_ack             = ha;
      cpu_run_ack              = ra;
      exp_q.push_back(model_step(f, w, s, ha, ra));
   endtask

   task automatic do_reset();
      @(negedge clk);
      cptra_rst_b              = 1'b0;
      fw_halt_req              = 1'b0;
      wake_event               = 1'b0;
      cptra_in_debug_scan_mode = 1'b0;
      cpu_halt_ack             = 1'b0;
      cpu_run_ack              = 1'b0;
      #1;
      checks++;
      if ({cpu_halt_req, cpu_run_req, cpu_halt_status, halt_timeout_err} !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset t=%0t got=%b exp=0000", $time,
                  {cpu_halt_req, cpu_run_req, cpu_halt_status, halt_timeout_err});
      end
      model_reset();
      exp_q.push_back(4'b0000);
   endtask

   // Monitor: after every active edge pop the expected outputs and compare.
   initial begin
      logic [3:0] e;
      logic [3:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {cpu_halt_req, cpu_run_req, cpu_halt_status, halt_timeout_err};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got(hreq,rreq,stat,err)=%b exp=%b", $time, got, e);
            end
         end
      end
   end

   initial begin
      int ack_pct;
      int wake_pct;
      model_reset();
      do_reset();

      // Halt with ack on the third cycle of the request, then resume with run ack two cycles later.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);

      // Halt request with no ack runs into the timeout.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < T + 3; i++) step(0, 0, 0, 0, 0);

      // Blocked entries, then a stuck halt ack while running.
      step(1, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

      // Ack arrives exactly on the timeout cycle.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < T; i++) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);

      // Run request times out twice, then is acknowledged.
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 2 * T + 4; i++) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);

      // Wake aborts a pending halt.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Reset in the middle of a halt request, and of a run request.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      do_reset();
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      do_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Randomized traffic with varying ack eagerness.
      for (int seg = 0; seg < 8; seg++) begin
         ack_pct  = (seg % 4 == 0) ? 0 : (seg % 4) * 25;
         wake_pct = (seg < 4) ? 5 : 20;
         for (int c = 0; c < 80; c++) begin
            if ($urandom_range(299) == 0) begin
               do_reset();
            end else begin
               step($urandom_range(99) < 20, $urandom_range(99) < wake_pct,
                    $urandom_range(99) < 10, $urandom_range(99) < ack_pct,
                    $urandom_range(99) < ack_pct);
            end
         end
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
